// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   master : requester side, drives start/a/b/cin and observes busy/done/sum/cout
//   slave  : adder side, the mirror image
// With SERIAL_ADDER_OVF_EN defined, the bundle also carries the signed overflow
// flag ovf, which sits alongside cout.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. It loads a, b and cin, then adds one bit
// per clock, LSB first, through a single full-adder cell and a carry flop. When
// the last bit is done it presents the registered sum and cout together with a
// one-cycle done pulse.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   serial_adder_if.slave. Inputs are start/a/b/cin; outputs are
//         busy/done/sum/cout, plus ovf when SERIAL_ADDER_OVF_EN is defined.
// Optional feature: SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow flag, computed as carry into MSB xor carry out of MSB.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   serial_adder_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
   logic             cmsb_q, cmsb_d;
   logic             ovf_q, ovf_d;
`endif

   // The single full-adder cell works on the current LSBs and the carry flop.
   assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
   assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         cmsb_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         cmsb_q  <= cmsb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_d  = cmsb_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            // While the done pulse is showing, a new start is ignored.
            if (bus.start && !done_q) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy_d  = 1'b1;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            // Each result bit enters from the MSB side. After WIDTH shifts the
            // first bit has reached bit 0.
            res_d   = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_ADDER_OVF_EN
               cmsb_d  = carry_q;
`endif
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            sum_d   = res_q;
            cout_d  = carry_q;
            done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_d   = cmsb_q ^ carry_q;
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder. It runs one 8-bit and
// one 1-bit instance. Directed and $urandom operands are checked against an
// arithmetic reference for result, latency, busy length, single done pulse,
// result stability, ignored starts, and reset behaviour.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder_if #(.WIDTH(1)) bus1 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int n_cmp = 0;
   int n_bad = 0;

   // Model of the last result each instance should be holding
   logic [7:0] m_sum8;
   logic       m_cout8, m_ovf8;
   logic       m_sum1, m_cout1, m_ovf1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer addition, with signed overflow judged from operand and result signs
   task automatic ref_add(input int w, input int unsigned a, input int unsigned b, input int unsigned c,
                          output int unsigned s, output int unsigned co, output int unsigned ov);
      int unsigned total, sign;
      total = a + b + c;
      s     = total & ((32'd1 << w) - 1);
      co    = (total >> w) & 1;
      sign  = 32'd1 << (w - 1);
      ov    = (((a & sign) == (b & sign)) && ((s & sign) != (a & sign))) ? 1 : 0;
   endtask

   // A stray start at sample 'inject' drives the operands 1+1+1, which must be ignored
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int inject, input string tag);
      int busy_n, done_n, done_at, unstable;
      int unsigned es, ec, eo;
      busy_n = 0; done_n = 0; done_at = -1; unstable = 0;
      ref_add(8, a, b, c, es, ec, eo);
      bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      for (int e = 0; e <= 14; e++) begin
         if (bus8.busy) busy_n++;
         if (bus8.done) begin
            done_n++;
            if (done_at < 0) done_at = e;
         end
         if (e < 9) begin
            if (bus8.sum !== m_sum8 || bus8.cout !== m_cout8) unstable++;
         end else if (bus8.sum !== 8'(es) || bus8.cout !== ec[0]) begin
            unstable++;
         end
         if (e == inject) begin
            bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b1;
         end else begin
            bus8.start = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus8.start = 1'b0;
      check($sformatf("%s busy_cycles", tag), busy_n, 8);
      check($sformatf("%s done_pulses", tag), done_n, 1);
      check($sformatf("%s done_latency", tag), done_at, 9);
      check($sformatf("%s sum_stable", tag), unstable, 0);
      check($sformatf("%s sum", tag), bus8.sum, es);
      check($sformatf("%s cout", tag), bus8.cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("%s ovf", tag), bus8.ovf, eo);
`endif
      m_sum8 = 8'(es); m_cout8 = ec[0]; m_ovf8 = eo[0];
   endtask

   task automatic run1(input logic a, input logic b, input logic c, input string tag);
      int busy_n, done_n, done_at, unstable;
      int unsigned es, ec, eo;
      busy_n = 0; done_n = 0; done_at = -1; unstable = 0;
      ref_add(1, 32'(a), 32'(b), 32'(c), es, ec, eo);
      bus1.a = a; bus1.b = b; bus1.cin = c; bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         if (bus1.busy) busy_n++;
         if (bus1.done) begin
            done_n++;
            if (done_at < 0) done_at = e;
         end
         if (e < 2) begin
            if (bus1.sum !== m_sum1 || bus1.cout !== m_cout1) unstable++;
         end else if (bus1.sum !== es[0] || bus1.cout !== ec[0]) begin
            unstable++;
         end
         @(posedge clk); #1;
      end
      check($sformatf("%s busy_cycles", tag), busy_n, 1);
      check($sformatf("%s done_pulses", tag), done_n, 1);
      check($sformatf("%s done_latency", tag), done_at, 2);
      check($sformatf("%s sum_stable", tag), unstable, 0);
      check($sformatf("%s sum", tag), bus1.sum, es);
      check($sformatf("%s cout", tag), bus1.cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("%s ovf", tag), bus1.ovf, eo);
`endif
      m_sum1 = es[0]; m_cout1 = ec[0]; m_ovf1 = eo[0];
   endtask

   // Watches a quiet period in which no busy and no done may appear
   task automatic quiet8(input int cycles, input string tag);
      int act;
      act = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus8.busy || bus8.done) act++;
         @(posedge clk); #1;
      end
      check($sformatf("%s no_activity", tag), act, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
      m_sum8 = '0; m_cout8 = 1'b0; m_ovf8 = 1'b0;
      m_sum1 = 1'b0; m_cout1 = 1'b0; m_ovf1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", bus8.busy, 0);
      check("reset done", bus8.done, 0);
      check("reset sum", bus8.sum, 0);
      check("reset cout", bus8.cout, 0);
      check("reset busy_w1", bus1.busy, 0);
      check("reset sum_w1", bus1.sum, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run8(8'h05, 8'h03, 1'b0, -1, "basic");
      run8(8'hFF, 8'h01, 1'b0, -1, "wrap");
      run8(8'hFF, 8'hFF, 1'b1, -1, "allones_cin");
      run8(8'h7F, 8'h01, 1'b0, -1, "pos_ovf");
      run8(8'h80, 8'h80, 1'b0, -1, "neg_ovf");
      run8(8'h10, 8'h20, 1'b0, -1, "no_ovf");
      run8(8'h05, 8'h03, 1'b0, 3, "start_while_busy");
      run8(8'h22, 8'h44, 1'b1, 9, "start_while_done");

      // Reset in the middle of a run
      bus8.a = 8'h05; bus8.b = 8'h03; bus8.cin = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst busy", bus8.busy, 0);
      check("midrst done", bus8.done, 0);
      check("midrst sum", bus8.sum, 0);
      check("midrst cout", bus8.cout, 0);
      m_sum8 = '0; m_cout8 = 1'b0; m_ovf8 = 1'b0;
      quiet8(12, "midrst");
      run8(8'h0A, 8'h05, 1'b0, -1, "after_rst");

      // When reset and start arrive together, reset wins
      rst = 1'b1; bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11;
      @(posedge clk); #1;
      rst = 1'b0; bus8.start = 1'b0;
      m_sum8 = '0; m_cout8 = 1'b0; m_ovf8 = 1'b0;
      check("rst_start sum", bus8.sum, 0);
      quiet8(12, "rst_start");

      for (int i = 0; i < 20; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), -1, $sformatf("rand%0d", i));
      end

      for (int k = 0; k < 8; k++) begin
         logic [2:0] v;
         v = 3'(k);
         run1(v[2], v[1], v[0], $sformatf("w1_%0d", k));
      end
      for (int i = 0; i < 4; i++) begin
         run1(1'($urandom), 1'($urandom), 1'($urandom), $sformatf("w1rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
